// File: rtl/code_conv_pkg.sv
// Shared types and defaults for the binary<->Gray conversion scheduler.
// The optional CODE_CONV_PARITY_EN build adds an out_parity port on code_conv_sched.
package code_conv_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } conv_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_NREQ  = 4;

endpackage

// File: rtl/code_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after rr_ptr, wrapping around to index 0.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic           hi_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate:
    // hi_idx is the first request at/after rr_ptr, lo_idx the wrap-around fallback.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDW'(i);
                if (IDW'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
    end

    assign any_grant = |req;
    assign grant_idx = hi_found ? hi_idx : lo_idx;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any_grant && (grant_idx == IDW'(i));
        end
    end

endmodule

// File: rtl/code_conv_sched.sv
// Round-robin scheduled binary<->Gray converter: b2g in one cycle, g2b bit-serial.
// Define CODE_CONV_PARITY_EN to add the registered out_parity output.
module code_conv_sched
    import code_conv_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NREQ  = DEFAULT_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]    req_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDW-1:0]     out_id,
`ifdef CODE_CONV_PARITY_EN
    output logic               out_parity,
`endif
    output logic               out_mode
);

    localparam int CW = $clog2(WIDTH);

    conv_state_e      state, state_nxt;
    conv_mode_e       op_mode;
    conv_mode_e       grant_mode;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] grant_data;
    logic [WIDTH-1:0] data_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant;
    logic             any_grant;
    logic             accept;
    logic [CW-1:0]    cnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_data = '0;
        grant_mode = MODE_B2G;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_data = req_data[i*WIDTH +: WIDTH];
                grant_mode = conv_mode_e'(req_mode[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_grant && rst_n) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (op_mode == MODE_B2G || cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);
    assign out_mode  = op_mode;

    // g2b seeds the result MSB on accept, then resolves one lower bit per CONV cycle.
    always_comb begin
        data_nxt = out_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    data_nxt = '0;
                    if (grant_mode == MODE_G2B) begin
                        data_nxt[WIDTH-1] = grant_data[WIDTH-1];
                    end
                end
            end
            CONV: begin
                if (op_mode == MODE_B2G) begin
                    data_nxt = op ^ (op >> 1);
                end else begin
                    data_nxt[cnt] = out_data[cnt + 1'b1] ^ op[cnt];
                end
            end
            default: data_nxt = out_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op       <= '0;
            op_mode  <= MODE_B2G;
            out_id   <= '0;
            out_data <= '0;
            cnt      <= '0;
        end else begin
            out_data <= data_nxt;
            if (accept) begin
                op      <= grant_data;
                op_mode <= grant_mode;
                out_id  <= grant_idx;
                cnt     <= CW'(WIDTH - 2);
                rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end else if (state == CONV && op_mode == MODE_G2B && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef CODE_CONV_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else begin
            out_parity <= ^data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_code_conv_sched.sv
// Directed self-checking bench for code_conv_sched (WIDTH=4, NREQ=4).
// Also checks out_parity when built with CODE_CONV_PARITY_EN.
module tb_code_conv_sched;
    import code_conv_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_mode;
`ifdef CODE_CONV_PARITY_EN
    logic                  out_parity;
`endif

    int checks = 0;
    int errors = 0;

    code_conv_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_mode   (req_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
`ifdef CODE_CONV_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_mode   (out_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_mode = '0;
        out_ready = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_data: got %b expected 0000", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_id: got %0d expected 0", out_id); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_mode: got %b expected 0", out_mode); end
`ifdef CODE_CONV_PARITY_EN
        checks++; if (out_parity !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_parity: got %b expected 0", out_parity); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_b2g();
        @(negedge clk);
        req_valid = 4'b0001; req_data = 16'h000B; req_mode = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL b2g_req_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2g_valid_early: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2g_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 4'b1110) begin errors++; $display("[TB] FAIL b2g_data: got %b expected 1110", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL b2g_id: got %0d expected 0", out_id); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("[TB] FAIL b2g_mode: got %b expected 0", out_mode); end
`ifdef CODE_CONV_PARITY_EN
        checks++; if (out_parity !== 1'b1) begin errors++; $display("[TB] FAIL b2g_parity: got %b expected 1", out_parity); end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2g_valid_clear: got %b expected 0", out_valid); end
    endtask

    task automatic test_g2b();
        @(negedge clk);
        req_valid = 4'b0100; req_data = 16'h0E00; req_mode = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL g2b_req_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0; req_mode = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL g2b_valid_early%0d: got %b expected 0", k, out_valid); end
            if (k < 2) @(negedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL g2b_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 4'b1011) begin errors++; $display("[TB] FAIL g2b_data: got %b expected 1011", out_data); end
        checks++; if (out_id !== 2'd2) begin errors++; $display("[TB] FAIL g2b_id: got %0d expected 2", out_id); end
        checks++; if (out_mode !== 1'b1) begin errors++; $display("[TB] FAIL g2b_mode: got %b expected 1", out_mode); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_order[5];
        logic [3:0] exp_res[4];
        int g, b, cyc;
        exp_order = '{0, 1, 2, 3, 0};
        exp_res = '{4'b0010, 4'b0101, 4'b1101, 4'b1010};
        do_reset();
        req_valid = 4'b1111; req_data = 16'hC963; req_mode = 4'b0000; out_ready = 1'b1;
        g = 0; b = 0; cyc = 0;
        while (b < 5 && cyc < 60) begin
            #1;
            checks++; if ($countones(req_ready) > 1) begin errors++; $display("[TB] FAIL rr_onehot: got %b expected at most one bit", req_ready); end
            if (req_ready != 4'b0000) begin
                if (g < 5) begin
                    checks++; if (req_ready !== (4'b0001 << exp_order[g])) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected index %0d", g, req_ready, exp_order[g]); end
                end
                g++;
            end
            if (out_valid === 1'b1) begin
                checks++; if (out_id !== 2'(exp_order[b])) begin errors++; $display("[TB] FAIL rr_id%0d: got %0d expected %0d", b, out_id, exp_order[b]); end
                checks++; if (out_data !== exp_res[exp_order[b]]) begin errors++; $display("[TB] FAIL rr_data%0d: got %b expected %b", b, out_data, exp_res[exp_order[b]]); end
                b++;
            end
            if (b == 5) req_valid = '0;
            @(negedge clk);
            cyc++;
        end
        checks++; if (b != 5) begin errors++; $display("[TB] FAIL rr_timeout: got %0d beats expected 5", b); end
        req_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 4'b1000; req_data = 16'h5000; req_mode = 4'b0000; out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL bp_req_ready: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010; req_data = 16'h0010; req_mode = 4'b0010;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", k, out_valid); end
            checks++; if (out_data !== 4'b0111) begin errors++; $display("[TB] FAIL bp_data%0d: got %b expected 0111", k, out_data); end
            checks++; if (out_id !== 2'd3) begin errors++; $display("[TB] FAIL bp_id%0d: got %0d expected 3", k, out_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready%0d: got %b expected 0000", k, req_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_clear: got %b expected 0", out_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_next_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0; req_mode = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp2_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 4'b0001) begin errors++; $display("[TB] FAIL bp2_data: got %b expected 0001", out_data); end
        checks++; if (out_id !== 2'd1) begin errors++; $display("[TB] FAIL bp2_id: got %0d expected 1", out_id); end
        checks++; if (out_mode !== 1'b1) begin errors++; $display("[TB] FAIL bp2_mode: got %b expected 1", out_mode); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 4'b0100; req_data = 16'h0D00; req_mode = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rm_req_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1111; req_data = 16'hC963; req_mode = 4'b0000;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("[TB] FAIL rm_data: got %b expected 0000", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL rm_id: got %0d expected 0", out_id); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("[TB] FAIL rm_mode: got %b expected 0", out_mode); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rm_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rm_first_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_stale: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_post_valid: got %b expected 1", out_valid); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL rm_post_id: got %0d expected 0", out_id); end
        checks++; if (out_data !== 4'b0010) begin errors++; $display("[TB] FAIL rm_post_data: got %b expected 0010", out_data); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_post_clear: got %b expected 0", out_valid); end
    endtask

    task automatic run_txn(input int idx, input logic [3:0] d, input logic m,
                           output logic [3:0] res, output logic [1:0] rid,
                           output logic rmode, output logic rpar, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001 << idx;
        req_data  = 16'(d) << (idx * WIDTH);
        req_mode  = 4'(m) << idx;
        #1;
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) ok = 1'b0;
        @(negedge clk);
        req_valid = '0; req_mode = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) ok = 1'b0;
        res = out_data; rid = out_id; rmode = out_mode;
`ifdef CODE_CONV_PARITY_EN
        rpar = out_parity;
`else
        rpar = 1'b0;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_round_trip();
        logic [3:0] v, g, exp_g, r;
        logic [1:0] rid;
        logic rmode, rpar;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            exp_g = v ^ (v >> 1);
            run_txn(0, v, 1'b0, g, rid, rmode, rpar, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rt_b2g_timeout%0d: got timeout expected beat", i); end
            checks++; if (g !== exp_g) begin errors++; $display("[TB] FAIL rt_b2g%0d: got %b expected %b", i, g, exp_g); end
`ifdef CODE_CONV_PARITY_EN
            checks++; if (rpar !== ^exp_g) begin errors++; $display("[TB] FAIL rt_b2g_parity%0d: got %b expected %b", i, rpar, ^exp_g); end
`endif
            run_txn(1, g, 1'b1, r, rid, rmode, rpar, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rt_g2b_timeout%0d: got timeout expected beat", i); end
            checks++; if (r !== v) begin errors++; $display("[TB] FAIL rt_g2b%0d: got %b expected %b", i, r, v); end
            checks++; if (rid !== 2'd1 || rmode !== 1'b1) begin errors++; $display("[TB] FAIL rt_tag%0d: got id %0d mode %b expected id 1 mode 1", i, rid, rmode); end
`ifdef CODE_CONV_PARITY_EN
            checks++; if (rpar !== ^v) begin errors++; $display("[TB] FAIL rt_g2b_parity%0d: got %b expected %b", i, rpar, ^v); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_b2g();
        test_g2b();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
